// File: rtl/reg_row_pkg.sv
// Shared definitions for the register-snapshot row bank and its store controller.
package reg_row_pkg;

  // Burst sequencer states
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_BURST     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  // Default burst geometry, kept in step with the store controller
  localparam logic [3:0] DEF_BASE_ROW   = 4'b1000;
  localparam int         DEF_BURST_ROWS = 4;

  // Row expected after idx rows of a burst have been accepted
  function automatic logic [3:0] burst_row(input logic [3:0] base, input logic [3:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/reg_row_mem.sv
// 16-row snapshot array: one write port, one registered read port, async clear.
module reg_row_mem #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem [16];

  // Row storage; the whole array clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-edge write to the row is not yet visible (old data returned)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/reg_row_bank.sv
// Row bank downstream of the store controller: stores rows, checks burst order,
// counts good bursts and flags sequence errors.
//
//  state       | meaning
//  S_IDLE      | no burst open; waiting for a write to BASE_ROW
//  S_BURST     | idx rows accepted; next cycle must write BASE_ROW+idx
//  S_WAIT_DONE | all rows written; waiting for rising edge of done
module reg_row_bank
  import reg_row_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter logic [3:0] BASE_ROW   = DEF_BASE_ROW,
  parameter int         BURST_ROWS = DEF_BURST_ROWS,
  parameter int         CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writemem,
  input  logic [3:0]        rowaddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              state_ctrl_done,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              burst_ok,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              seq_err,
  input  logic              err_clr
);

  localparam logic [3:0] LAST_IDX = 4'(BURST_ROWS - 1);
  localparam bit         ONE_ROW  = (BURST_ROWS == 1);

  logic [1:0] state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic       done_q;
  logic       done_rise;
  logic       err_set;
  logic       ok_set;

  assign done_rise = state_ctrl_done & ~done_q;

  reg_row_mem #(.DATA_W(DATA_W)) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (writemem),
    .waddr    (rowaddr),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // Burst order checker; a write in S_WAIT_DONE takes priority over done so
  // ok and error never come from the same cycle
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_set   = 1'b0;
    ok_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (writemem) begin
          if (rowaddr == BASE_ROW) begin
            state_nxt = ONE_ROW ? S_WAIT_DONE : S_BURST;
            idx_nxt   = 4'd1;
          end else begin
            err_set = 1'b1;
          end
        end else if (done_rise) begin
          err_set = 1'b1;
        end
      end
      S_BURST: begin
        if (writemem && !done_rise && rowaddr == burst_row(BASE_ROW, idx)) begin
          idx_nxt = idx + 4'd1;
          if (idx == LAST_IDX) state_nxt = S_WAIT_DONE;
        end else begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
          idx_nxt   = 4'd0;
        end
      end
      S_WAIT_DONE: begin
        if (writemem) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
          idx_nxt   = 4'd0;
        end else if (done_rise) begin
          ok_set    = 1'b1;
          state_nxt = S_IDLE;
          idx_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  // FSM, done edge detect, burst counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      done_q    <= 1'b0;
      burst_ok  <= 1'b0;
      burst_cnt <= '0;
      seq_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      done_q   <= state_ctrl_done;
      burst_ok <= ok_set;
      if (ok_set && burst_cnt != {CNT_W{1'b1}}) burst_cnt <= burst_cnt + 1'b1;
      seq_err  <= err_set | (seq_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_reg_row_bank.sv
// Directed + randomized bench for reg_row_bank against a row-sequence reference model.
module tb_reg_row_bank;

  localparam int         BURST = 4;
  localparam logic [3:0] BASE  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        writemem;
  logic [3:0]  rowaddr;
  logic [31:0] wdata;
  logic        state_ctrl_done;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        burst_ok;
  logic [7:0]  burst_cnt;
  logic        seq_err;
  logic        err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: pos = rows accepted in the open burst (0 = none, BURST = waiting for done)
  int          pos;
  logic [31:0] m_mem [16];
  logic        m_done_q;
  int          m_cnt;
  logic        m_seq;
  logic        m_ok;
  logic [31:0] m_rd;
  logic        m_rv;

  reg_row_bank dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .writemem        (writemem),
    .rowaddr         (rowaddr),
    .wdata           (wdata),
    .state_ctrl_done (state_ctrl_done),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .burst_ok        (burst_ok),
    .burst_cnt       (burst_cnt),
    .seq_err         (seq_err),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_done_q = 1'b0;
    m_cnt = 0;
    m_seq = 1'b0;
    m_ok  = 1'b0;
    m_rd  = 32'h0;
    m_rv  = 1'b0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ":rd_data"},   rd_data, m_rd);
    chk({ctx, ":rd_valid"},  {31'h0, rd_valid}, {31'h0, m_rv});
    chk({ctx, ":burst_ok"},  {31'h0, burst_ok}, {31'h0, m_ok});
    chk({ctx, ":burst_cnt"}, {24'h0, burst_cnt}, 32'(m_cnt));
    chk({ctx, ":seq_err"},   {31'h0, seq_err}, {31'h0, m_seq});
  endtask

  // one clock: drive inputs, advance model, check after the edge
  task automatic step(input logic wm, input logic [3:0] ra, input logic [31:0] wd,
                      input logic dn, input logic re, input logic [3:0] rad,
                      input logic clr, input string ctx);
    logic rise, bad;
    writemem = wm; rowaddr = ra; wdata = wd; state_ctrl_done = dn;
    rd_en = re; rd_addr = rad; err_clr = clr;
    rise = dn && !m_done_q;
    m_done_q = dn;
    m_ok = 1'b0;
    bad = 1'b0;
    if (pos == 0) begin
      if (wm) begin
        if (ra == BASE) pos = 1;
        else bad = 1'b1;
      end else if (rise) bad = 1'b1;
    end else if (pos < BURST) begin
      if (wm && !rise && int'(ra) == int'(BASE) + pos) pos++;
      else begin bad = 1'b1; pos = 0; end
    end else begin
      if (wm) begin bad = 1'b1; pos = 0; end
      else if (rise) begin
        m_ok = 1'b1;
        if (m_cnt < 255) m_cnt++;
        pos = 0;
      end
    end
    m_seq = bad || (m_seq && !clr);
    m_rv = re;
    if (re) m_rd = m_mem[rad];
    if (wm) m_mem[ra] = wd;
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, ctx);
  endtask

  task automatic good_burst(input int done_len, input string ctx);
    for (int r = 0; r < BURST; r++)
      step(1'b1, BASE + 4'(r), $urandom, 1'b0, 1'b0, 4'd0, 1'b0, ctx);
    for (int d = 0; d < done_len; d++)
      step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, ctx);
    idle(ctx);
  endtask

  task automatic do_reset(input string ctx);
    writemem = 1'b0; rowaddr = 4'd0; wdata = 32'h0; state_ctrl_done = 1'b0;
    rd_en = 1'b0; rd_addr = 4'd0; err_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a [4];
    logic [3:0]  ra;
    int          r;

    rst_n = 1'b1;
    #2;
    do_reset("reset");
    idle("post_reset");

    // 1: good burst, done one cycle after last row, then read rows back
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    for (int i = 0; i < 4; i++) step(1'b1, BASE + 4'(i), a[i], 1'b0, 1'b0, 4'd0, 1'b0, "t1_wr");
    step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, "t1_done");
    chk("t1_ok_pulse", {31'h0, burst_ok}, 32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, "t1_done_low");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, BASE + 4'(i), 1'b0, "t1_rd");
      chk("t1_rd_value", rd_data, a[i]);
    end
    idle("t1_end");

    // 2: skipped row
    step(1'b1, 4'd8,  32'h1111_0008, 1'b0, 1'b0, 4'd0, 1'b0, "t2_wr");
    step(1'b1, 4'd9,  32'h1111_0009, 1'b0, 1'b0, 4'd0, 1'b0, "t2_wr");
    step(1'b1, 4'd11, 32'h1111_000b, 1'b0, 1'b0, 4'd0, 1'b0, "t2_wr11");
    chk("t2_seq_err", {31'h0, seq_err}, 32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd11, 1'b0, "t2_rd11");
    chk("t2_row11", rd_data, 32'h1111_000b);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, "t2_clr");

    // 3: done held high for 5 cycles counts once
    good_burst(5, "t3");
    chk("t3_cnt", {24'h0, burst_cnt}, 32'd2);

    // 4: reset mid-burst, then a full burst
    step(1'b1, 4'd8, 32'hAAAA_0008, 1'b0, 1'b0, 4'd0, 1'b0, "t4_wr");
    step(1'b1, 4'd9, 32'hAAAA_0009, 1'b0, 1'b0, 4'd0, 1'b0, "t4_wr");
    @(negedge clk);
    do_reset("t4_reset");
    good_burst(1, "t4_burst");
    chk("t4_cnt", {24'h0, burst_cnt}, 32'd1);

    // 5: saturation
    for (int b = 0; b < 300; b++) good_burst(1, "t5");
    chk("t5_sat", {24'h0, burst_cnt}, 32'd255);

    // 6: read-before-write on one row; clear together with a new error
    step(1'b1, 4'd9, 32'h0000_BEEF, 1'b0, 1'b0, 4'd0, 1'b0, "t6_seed");
    chk("t6_seed_err", {31'h0, seq_err}, 32'd1);
    step(1'b1, 4'd9, 32'h0000_DEAD, 1'b0, 1'b1, 4'd9, 1'b1, "t6_rbw");
    chk("t6_old_data", rd_data, 32'h0000_BEEF);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd9, 1'b1, "t6_new_data");
    chk("t6_cleared", {31'h0, seq_err}, 32'd0);
    step(1'b1, 4'd3, 32'h3, 1'b0, 1'b0, 4'd0, 1'b1, "t6_set_wins");
    chk("t6_set_wins", {31'h0, seq_err}, 32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, "t6_clr");

    // randomized traffic biased toward legal bursts
    do_reset("rand_reset");
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (pos == BURST) begin
        ra = 4'($urandom_range(0, 15));
        step(r == 0, ra, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             $urandom_range(0, 7) == 0, "rand");
      end else begin
        ra = (r < 6) ? BASE + 4'(pos) : 4'($urandom_range(0, 15));
        step(r < 8, ra, $urandom, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             $urandom_range(0, 7) == 0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
